// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// UART receive frame controller. It sits beside an external RX bit counter and
// an external prescale edge counter. It detects the start bit, enables both
// counters, samples the line mid-bit and deserialises 8 data bits LSB-first.
// It then checks the optional parity bit and the stop bit and presents
// good bytes to the downstream frame decoder.
//
// Build option: define UART_RX_MAJORITY_SAMPLE_EN to take a 2-of-3 majority
// vote over three mid-bit samples. Without it, a single sample at the bit
// centre is used. State timing is the same in both builds.
//
// Ports
//   clk            oversampling clock, one edge_count tick per cycle
//   rst            asynchronous reset, active-low
//   rx_in_i        serial line, idle high
//   par_en_i       frame carries a parity bit
//   par_typ_i      0 = even parity, 1 = odd parity
//   edge_count_i   tick index within the current bit (0..PRESCALE-1)
//   edge_done_i    last tick of the current bit
//   bit_count_i    0 start, 1..8 data, 9 parity/stop, 10 stop
//   en_o           counter enable, high whenever the FSM is not idle
//   p_data_o       last good byte, held until the next good frame
//   data_valid_o   one-cycle pulse when p_data_o is updated
//   par_err_o      one-cycle pulse at frame end on parity mismatch
//   stp_err_o      one-cycle pulse at frame end when the stop bit is low
//
// State table
//   state    | meaning
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | start bit, glitch check at MID+2
//   S_DATA   | shifting in data bits 1..8
//   S_PARITY | parity bit, mismatch latched at bit end
//   S_STOP   | stop bit, results and pulses issued at bit end

module uart_rx_frame_ctrl #(
    parameter int PRESCALE = 8,
    parameter int EC_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_in_i,
    input  logic                par_en_i,
    input  logic                par_typ_i,
    input  logic [EC_WIDTH-1:0] edge_count_i,
    input  logic                edge_done_i,
    input  logic [3:0]          bit_count_i,
    output logic                en_o,
    output logic [7:0]          p_data_o,
    output logic                data_valid_o,
    output logic                par_err_o,
    output logic                stp_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [EC_WIDTH-1:0] EC_MID   = EC_WIDTH'(PRESCALE / 2);
    localparam logic [EC_WIDTH-1:0] EC_MID_M = EC_WIDTH'(PRESCALE / 2 - 1);
    localparam logic [EC_WIDTH-1:0] EC_MID_P = EC_WIDTH'(PRESCALE / 2 + 1);
    localparam logic [EC_WIDTH-1:0] EC_CHECK = EC_WIDTH'(PRESCALE / 2 + 2);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] p_data_q, p_data_d;
    logic       par_bad_q, par_bad_d;
    logic       data_valid_q, data_valid_d;
    logic       par_err_q, par_err_d;
    logic       stp_err_q, stp_err_d;
    logic       sampled_bit;
    logic [2:0] bit_idx;

    assign en_o    = (state_q != S_IDLE);
    assign bit_idx = 3'(bit_count_i - 4'd1);

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic samp_lo_q, samp_mid_q, samp_hi_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_lo_q  <= 1'b0;
            samp_mid_q <= 1'b0;
            samp_hi_q  <= 1'b0;
        end else if (en_o) begin
            if (edge_count_i == EC_MID_M) samp_lo_q  <= rx_in_i;
            if (edge_count_i == EC_MID)   samp_mid_q <= rx_in_i;
            if (edge_count_i == EC_MID_P) samp_hi_q  <= rx_in_i;
        end
    end

    assign sampled_bit = (samp_lo_q & samp_mid_q) | (samp_lo_q & samp_hi_q) |
                         (samp_mid_q & samp_hi_q);
`else
    logic samp_mid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_mid_q <= 1'b0;
        end else if (en_o && (edge_count_i == EC_MID)) begin
            samp_mid_q <= rx_in_i;
        end
    end

    assign sampled_bit = samp_mid_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            p_data_q     <= 8'h00;
            par_bad_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_bad_q    <= par_bad_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_bad_d    = par_bad_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A frame without parity must not inherit the previous verdict.
                par_bad_d = 1'b0;
                if (!rx_in_i) state_d = S_START;
            end
            S_START: begin
                // Dropping en here, before edge_done, keeps the bit counter at 0.
                if ((edge_count_i == EC_CHECK) && sampled_bit) begin
                    state_d = S_IDLE;
                end else if (edge_done_i) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (edge_done_i) begin
                    if ((bit_count_i != 4'd0) && (bit_count_i <= 4'd8)) begin
                        shift_d[bit_idx] = sampled_bit;
                    end
                    if (bit_count_i == 4'd8) begin
                        state_d = par_en_i ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (edge_done_i) begin
                    par_bad_d = sampled_bit ^ (^shift_q) ^ par_typ_i;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (edge_done_i) begin
                    state_d   = S_IDLE;
                    stp_err_d = ~sampled_bit;
                    par_err_d = par_bad_q & par_en_i;
                    if (sampled_bit && !par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p_data_o     = p_data_q;
    assign data_valid_o = data_valid_q;
    assign par_err_o    = par_err_q;
    assign stp_err_o    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam int PRESCALE = 8;
    localparam int EC_WIDTH = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                rx_in = 1'b1;
    logic                par_en = 1'b0;
    logic                par_typ = 1'b0;
    logic [EC_WIDTH-1:0] edge_count;
    logic                edge_done;
    logic [3:0]          bit_count;
    logic                en;
    logic [7:0]          p_data;
    logic                data_valid;
    logic                par_err;
    logic                stp_err;

    uart_rx_frame_ctrl #(.PRESCALE(PRESCALE), .EC_WIDTH(EC_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in_i      (rx_in),
        .par_en_i     (par_en),
        .par_typ_i    (par_typ),
        .edge_count_i (edge_count),
        .edge_done_i  (edge_done),
        .bit_count_i  (bit_count),
        .en_o         (en),
        .p_data_o     (p_data),
        .data_valid_o (data_valid),
        .par_err_o    (par_err),
        .stp_err_o    (stp_err)
    );

    always #5 clk = ~clk;

    // Models of the neighbouring prescale edge counter and RX bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
            bit_count  <= 4'd0;
        end else if (!en) begin
            edge_count <= '0;
            bit_count  <= 4'd0;
        end else if (edge_count == EC_WIDTH'(PRESCALE - 1)) begin
            edge_count <= '0;
            if (bit_count == (par_en ? 4'd10 : 4'd9)) bit_count <= 4'd0;
            else                                     bit_count <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 1'b1;
        end
    end
    assign edge_done = (edge_count == EC_WIDTH'(PRESCALE - 1));

    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   en_cycles = 0;
    int   dv_count = 0;

    // Monitor: every output pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        exp_t e;
        if (en) en_cycles++;
        if (rst && (data_valid || par_err || stp_err)) begin
            if (data_valid) dv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual dv=%0b pe=%0b se=%0b p_data=%02h required no pulse",
                         data_valid, par_err, stp_err, p_data);
            end else begin
                e = exp_q.pop_front();
                if ({data_valid, par_err, stp_err, p_data} !== {e.dv, e.pe, e.se, e.data}) begin
                    errors++;
                    $display("FAIL frame_result actual dv=%0b pe=%0b se=%0b p_data=%02h required dv=%0b pe=%0b se=%0b p_data=%02h",
                             data_valid, par_err, stp_err, p_data, e.dv, e.pe, e.se, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sends one frame. glitch_bit: frame bit index receiving a one-tick inversion
    // at the tick sampled at edge_count==MID. rst_bit: frame bit index at which
    // reset is pulsed and the frame abandoned.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit, input int glitch_bit, input int rst_bit);
        logic bits[11];
        int   nbits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pen) begin
            bits[9] = pbit; bits[10] = sbit; nbits = 11;
        end else begin
            bits[9] = sbit; bits[10] = 1'b1; nbits = 10;
        end
        @(negedge clk);
        par_en = pen;
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                @(negedge clk);
                rx_in = 1'b1;
                rst   = 1'b0;
                #1;
                check("rst_en_low", {31'd0, en}, 32'd0);
                check("rst_p_data", {24'd0, p_data}, 32'd0);
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (2 * PRESCALE) @(negedge clk);
                return;
            end
            for (int c = 0; c < PRESCALE; c++) begin
                @(negedge clk);
                rx_in = (b == glitch_bit && c == PRESCALE / 2 + 1) ? ~bits[b] : bits[b];
            end
        end
        @(negedge clk);
        rx_in = 1'b1;
        repeat (2 * PRESCALE) @(negedge clk);
    endtask

    task automatic expect_frame(input logic dv, input logic pe, input logic se, input logic [7:0] data);
        exp_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        int start;
        int dv_start;
        logic [7:0] glitch_exp;

        repeat (3) @(negedge clk);
        check("reset_en", {31'd0, en}, 32'd0);
        check("reset_p_data", {24'd0, p_data}, 32'd0);
        check("reset_pulses", {29'd0, data_valid, par_err, stp_err}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5
        expect_frame(1'b1, 1'b0, 1'b0, 8'hA5);
        start = en_cycles;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, -1);
        check("8n1_en_cycles", en_cycles - start, 32'd80);
        check("8n1_pending", exp_q.size(), 32'd0);

        // 8E1 0x3C with correct parity (0x3C has four ones -> parity bit 0)
        par_typ = 1'b0;
        expect_frame(1'b1, 1'b0, 1'b0, 8'h3C);
        start = en_cycles;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, -1);
        check("8e1_en_cycles", en_cycles - start, 32'd88);
        check("8e1_pending", exp_q.size(), 32'd0);

        // 8E1 0x3C with wrong parity bit -> par_err, p_data holds
        expect_frame(1'b0, 1'b1, 1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
        check("8e1_bad_pending", exp_q.size(), 32'd0);

        // 8O1 0x01 (odd parity bit 0) with stop bit low -> stp_err only
        par_typ = 1'b1;
        expect_frame(1'b0, 1'b0, 1'b1, 8'h3C);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, -1, -1);
        check("8o1_stop_pending", exp_q.size(), 32'd0);
        check("8o1_bit_count_zero", {28'd0, bit_count}, 32'd0);
        check("8o1_en_low", {31'd0, en}, 32'd0);
        par_typ = 1'b0;
        par_en  = 1'b0;

        // Start-bit glitch: low for three ticks, then high
        start = en_cycles;
        repeat (3) begin
            @(negedge clk);
            rx_in = 1'b0;
        end
        @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * PRESCALE) @(negedge clk);
        check("glitch_en_short", {31'd0, (en_cycles - start) <= 7}, 32'd1);
        check("glitch_en_seen", {31'd0, (en_cycles - start) > 0}, 32'd1);
        check("glitch_en_low", {31'd0, en}, 32'd0);
        check("glitch_bit_count", {28'd0, bit_count}, 32'd0);

        // Mid-bit glitch on data bit 0 of 0xFF
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        glitch_exp = 8'hFF;
`else
        glitch_exp = 8'hFE;
`endif
        expect_frame(1'b1, 1'b0, 1'b0, glitch_exp);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1, -1);
        check("midglitch_pending", exp_q.size(), 32'd0);

        // Reset during data bit 4 of 0x55, then a clean 0x0F
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 5);
        check("abort_en_low", {31'd0, en}, 32'd0);
        dv_start = dv_count;
        expect_frame(1'b1, 1'b0, 1'b0, 8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, -1);
        check("after_rst_pending", exp_q.size(), 32'd0);
        check("after_rst_one_valid", dv_count - dv_start, 32'd1);
        check("after_rst_p_data", {24'd0, p_data}, 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
